// File: rtl/compressor_pkg.sv
// Shared shape constants and types for the 23x23 bit-heap compressor.
package compressor_pkg;

  localparam int unsigned N_COLS = 23;
  localparam int unsigned COL_H  = 23;
  localparam int unsigned OUT_W  = 28;

  typedef logic [COL_H-1:0] col_t;
  typedef logic [OUT_W-1:0] sum_t;

endpackage

// File: rtl/full_adder.sv
// 3:2 counter used as the basic cell of the reduction tree.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/compressor_tree_23x23.sv
// Registered bit-heap compressor: sum over k of popcount(src_k) * 2^k, one cycle latency.
module compressor_tree_23x23
  import compressor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [COL_H-1:0] src0,
  input  logic [COL_H-1:0] src1,
  input  logic [COL_H-1:0] src2,
  input  logic [COL_H-1:0] src3,
  input  logic [COL_H-1:0] src4,
  input  logic [COL_H-1:0] src5,
  input  logic [COL_H-1:0] src6,
  input  logic [COL_H-1:0] src7,
  input  logic [COL_H-1:0] src8,
  input  logic [COL_H-1:0] src9,
  input  logic [COL_H-1:0] src10,
  input  logic [COL_H-1:0] src11,
  input  logic [COL_H-1:0] src12,
  input  logic [COL_H-1:0] src13,
  input  logic [COL_H-1:0] src14,
  input  logic [COL_H-1:0] src15,
  input  logic [COL_H-1:0] src16,
  input  logic [COL_H-1:0] src17,
  input  logic [COL_H-1:0] src18,
  input  logic [COL_H-1:0] src19,
  input  logic [COL_H-1:0] src20,
  input  logic [COL_H-1:0] src21,
  input  logic [COL_H-1:0] src22,
  output logic             dst0,
  output logic             dst1,
  output logic             dst2,
  output logic             dst3,
  output logic             dst4,
  output logic             dst5,
  output logic             dst6,
  output logic             dst7,
  output logic             dst8,
  output logic             dst9,
  output logic             dst10,
  output logic             dst11,
  output logic             dst12,
  output logic             dst13,
  output logic             dst14,
  output logic             dst15,
  output logic             dst16,
  output logic             dst17,
  output logic             dst18,
  output logic             dst19,
  output logic             dst20,
  output logic             dst21,
  output logic             dst22,
  output logic             dst23,
  output logic             dst24,
  output logic             dst25,
  output logic             dst26,
  output logic             dst27
);

  localparam int unsigned NStages = COL_H - 1;

  col_t src [N_COLS];
  sum_t rows [COL_H];
  sum_t ps [NStages];
  sum_t pc [NStages];
  sum_t sum_d, sum_q;

  assign src[0]  = src0;
  assign src[1]  = src1;
  assign src[2]  = src2;
  assign src[3]  = src3;
  assign src[4]  = src4;
  assign src[5]  = src5;
  assign src[6]  = src6;
  assign src[7]  = src7;
  assign src[8]  = src8;
  assign src[9]  = src9;
  assign src[10] = src10;
  assign src[11] = src11;
  assign src[12] = src12;
  assign src[13] = src13;
  assign src[14] = src14;
  assign src[15] = src15;
  assign src[16] = src16;
  assign src[17] = src17;
  assign src[18] = src18;
  assign src[19] = src19;
  assign src[20] = src20;
  assign src[21] = src21;
  assign src[22] = src22;

  // Transpose the dot array: row r holds bit r of every column at its column weight.
  always_comb begin
    for (int r = 0; r < COL_H; r++) begin
      rows[r] = '0;
      for (int k = 0; k < N_COLS; k++) begin
        rows[r][k] = src[k][r];
      end
    end
  end

  // First two rows merge through a layer of half adders.
  assign ps[0] = rows[0] ^ rows[1];
  assign pc[0] = (rows[0] & rows[1]) << 1;

  // Each further row is folded into the redundant (sum, carry) pair by a row of full adders.
  // The carry out of the top column is always 0 because the total fits in OUT_W bits.
  for (genvar s = 1; s < NStages; s++) begin : g_stage
    logic [OUT_W-2:0] cy;
    for (genvar b = 0; b < OUT_W - 1; b++) begin : g_bit
      full_adder u_fa (
        .a    (ps[s-1][b]),
        .b    (pc[s-1][b]),
        .cin  (rows[s+1][b]),
        .s    (ps[s][b]),
        .cout (cy[b])
      );
    end
    assign ps[s][OUT_W-1] = ps[s-1][OUT_W-1] ^ pc[s-1][OUT_W-1] ^ rows[s+1][OUT_W-1];
    assign pc[s]          = {cy, 1'b0};
  end

  assign sum_d = ps[NStages-1] + pc[NStages-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign dst0  = sum_q[0];
  assign dst1  = sum_q[1];
  assign dst2  = sum_q[2];
  assign dst3  = sum_q[3];
  assign dst4  = sum_q[4];
  assign dst5  = sum_q[5];
  assign dst6  = sum_q[6];
  assign dst7  = sum_q[7];
  assign dst8  = sum_q[8];
  assign dst9  = sum_q[9];
  assign dst10 = sum_q[10];
  assign dst11 = sum_q[11];
  assign dst12 = sum_q[12];
  assign dst13 = sum_q[13];
  assign dst14 = sum_q[14];
  assign dst15 = sum_q[15];
  assign dst16 = sum_q[16];
  assign dst17 = sum_q[17];
  assign dst18 = sum_q[18];
  assign dst19 = sum_q[19];
  assign dst20 = sum_q[20];
  assign dst21 = sum_q[21];
  assign dst22 = sum_q[22];
  assign dst23 = sum_q[23];
  assign dst24 = sum_q[24];
  assign dst25 = sum_q[25];
  assign dst26 = sum_q[26];
  assign dst27 = sum_q[27];

endmodule

// File: tb/tb_compressor_tree_23x23.sv
// Self-checking bench: directed cases plus random streaming against an arithmetic reference.
module tb_compressor_tree_23x23;

  logic        clk;
  logic        rst;
  logic [22:0] src [23];
  logic [27:0] dst;

  int unsigned n_checks;
  int unsigned n_errors;

  compressor_tree_23x23 dut (
    .clk   (clk),
    .rst   (rst),
    .src0  (src[0]),
    .src1  (src[1]),
    .src2  (src[2]),
    .src3  (src[3]),
    .src4  (src[4]),
    .src5  (src[5]),
    .src6  (src[6]),
    .src7  (src[7]),
    .src8  (src[8]),
    .src9  (src[9]),
    .src10 (src[10]),
    .src11 (src[11]),
    .src12 (src[12]),
    .src13 (src[13]),
    .src14 (src[14]),
    .src15 (src[15]),
    .src16 (src[16]),
    .src17 (src[17]),
    .src18 (src[18]),
    .src19 (src[19]),
    .src20 (src[20]),
    .src21 (src[21]),
    .src22 (src[22]),
    .dst0  (dst[0]),
    .dst1  (dst[1]),
    .dst2  (dst[2]),
    .dst3  (dst[3]),
    .dst4  (dst[4]),
    .dst5  (dst[5]),
    .dst6  (dst[6]),
    .dst7  (dst[7]),
    .dst8  (dst[8]),
    .dst9  (dst[9]),
    .dst10 (dst[10]),
    .dst11 (dst[11]),
    .dst12 (dst[12]),
    .dst13 (dst[13]),
    .dst14 (dst[14]),
    .dst15 (dst[15]),
    .dst16 (dst[16]),
    .dst17 (dst[17]),
    .dst18 (dst[18]),
    .dst19 (dst[19]),
    .dst20 (dst[20]),
    .dst21 (dst[21]),
    .dst22 (dst[22]),
    .dst23 (dst[23]),
    .dst24 (dst[24]),
    .dst25 (dst[25]),
    .dst26 (dst[26]),
    .dst27 (dst[27])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%07h expected 0x%07h", tag, got, exp);
    end
  endtask

  // Reference: weighted popcount sum in plain integer arithmetic.
  function automatic logic [27:0] ref_sum();
    longint unsigned acc = 0;
    for (int k = 0; k < 23; k++) begin
      acc += longint'($countones(src[k])) << k;
    end
    return acc[27:0];
  endfunction

  task automatic set_all(input logic [22:0] v);
    for (int k = 0; k < 23; k++) src[k] = v;
  endtask

  // Apply current src/rst at the next edge and compare the registered result.
  task automatic step_check(input string tag, input logic [27:0] exp);
    @(posedge clk);
    #1;
    check(tag, dst, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [27:0] exp_v;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_all(23'h7FFFFF);
    @(negedge clk);

    step_check("reset_edge1", 28'h0);
    step_check("reset_edge2", 28'h0);
    rst = 1'b0;
    step_check("all_ones", 28'hB7FFFE9);

    set_all(23'h0);
    step_check("all_zero", 28'h0);

    src[22] = 23'h000001;
    step_check("src22_lsb", 28'h0400000);
    src[22] = 23'h0;

    src[0] = 23'h400000;
    step_check("src0_msb", 28'h0000001);

    src[0] = 23'h7FFFFF;
    step_check("full_col0", 28'd23);
    src[0] = 23'h0;

    for (int k = 0; k < 23; k++) src[k] = 23'(1 << k);
    step_check("one_per_col", 28'h07FFFFF);

    set_all(23'h7FFFFF);
    step_check("stream_ones", 28'hB7FFFE9);
    set_all(23'h0);
    step_check("stream_zero", 28'h0);
    src[1] = 23'h000003;
    step_check("stream_src1", 28'd4);

    for (int i = 0; i < 10000; i++) begin
      int unsigned mode;
      mode = $urandom_range(0, 9);
      for (int k = 0; k < 23; k++) begin
        unique case (mode)
          0:       src[k] = 23'h7FFFFF;
          1:       src[k] = 23'h0;
          2:       src[k] = 23'($urandom) & 23'($urandom);
          default: src[k] = 23'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 19) == 0);
      exp_v = rst ? 28'h0 : ref_sum();
      step_check(rst ? "rand_rst" : "rand", exp_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
